// File: rtl/mux8_rr_sched_if.sv
// Request/grant bundle between the eight requesters and the round-robin scheduler.
// The master side drives requests; the slave side is the scheduler itself.
interface mux8_rr_sched_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;
  logic [2:0] ptr;

  modport master (output req, input gnt, sel, valid, ptr);
  modport slave  (input req, output gnt, sel, valid, ptr);
endinterface

// File: rtl/mux8_rr_sched.sv
// Round-robin owner of the mux8to1 select: one grant at a time, bounded hold when
// others wait, and a mandatory idle cycle between grants.
module mux8_rr_sched #(
  parameter int HOLD_MAX = 15
) (
  input logic            clk,
  input logic            rst,
  mux8_rr_sched_if.slave bus
);
  localparam int CW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX);
  localparam logic PREEMPT = (HOLD_MAX != 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nx;
  logic [2:0]    sel_q, sel_nx;
  logic [2:0]    ptr_q, ptr_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [7:0]    gnt_w;
  logic          valid_w;
  logic [2:0]    win, idx;
  logic          found, others, drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel_q <= 3'd0;
      ptr_q <= 3'd0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      sel_q <= sel_nx;
      ptr_q <= ptr_nx;
      cnt_q <= cnt_nx;
    end
  end

  // Search starts at ptr so the last released channel is checked last.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign others = |(bus.req & ~gnt_w);
  assign drop   = !bus.req[sel_q] || (PREEMPT && (cnt_q == CNT_MAX) && others);

  always_comb begin
    state_nx = state;
    sel_nx   = sel_q;
    ptr_nx   = ptr_q;
    cnt_nx   = cnt_q;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          sel_nx   = win;
          cnt_nx   = CW'(1);
        end
      end
      GRANT: begin
        if (drop) begin
          state_nx = IDLE;
          ptr_nx   = sel_q + 3'd1;
        end else if (PREEMPT && (cnt_q != CNT_MAX)) begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt_w   = 8'h00;
    valid_w = 1'b0;
    if (state == GRANT) begin
      gnt_w   = 8'b1 << sel_q;
      valid_w = 1'b1;
    end
  end

  assign bus.gnt   = gnt_w;
  assign bus.valid = valid_w;
  assign bus.sel   = sel_q;
  assign bus.ptr   = ptr_q;
endmodule

// File: tb/tb_mux8_rr_sched.sv
// Directed bench for mux8_rr_sched (HOLD_MAX=4): a queue-free owner/pointer model is
// compared every cycle, and hand-computed checkpoints pin that model down.
module tb_mux8_rr_sched;
  localparam int HOLD = 4;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  mux8_rr_sched_if bus ();

  mux8_rr_sched #(.HOLD_MAX(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: owner is the granted channel or -1, run counts valid cycles so far.
  int m_owner = -1;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_run   = 0;
  bit m_live  = 1'b0;

  always @(posedge clk) begin
    int  nown, nsel, nptr, nrun;
    bit  waiting;
    nown = m_owner;
    nsel = m_sel;
    nptr = m_ptr;
    nrun = m_run;
    if (rst) begin
      nown = -1;
      nsel = 0;
      nptr = 0;
      nrun = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (nown < 0 && bus.req[(m_ptr + k) % 8]) begin
          nown = (m_ptr + k) % 8;
          nsel = nown;
          nrun = 1;
        end
      end
    end else begin
      waiting = (bus.req & ~(8'd1 << m_owner)) != 8'h00;
      if (!bus.req[m_owner] || (HOLD > 0 && m_run >= HOLD && waiting)) begin
        nown = -1;
        nptr = (m_owner + 1) % 8;
      end else if (nrun < HOLD) begin
        nrun = nrun + 1;
      end
    end
    m_owner <= nown;
    m_sel   <= nsel;
    m_ptr   <= nptr;
    m_run   <= nrun;
    m_live  <= 1'b1;
  end

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] s,
                            input logic v, input logic [2:0] p);
    check_output({tag, ".gnt"}, bus.gnt, g);
    check_output({tag, ".sel"}, 8'(bus.sel), 8'(s));
    check_output({tag, ".valid"}, 8'(bus.valid), 8'(v));
    check_output({tag, ".ptr"}, 8'(bus.ptr), 8'(p));
  endtask

  always @(negedge clk) begin
    logic [7:0] exp_gnt;
    if (m_live) begin
      exp_gnt = (m_owner < 0) ? 8'h00 : 8'(8'd1 << m_owner);
      check_output("model.gnt", bus.gnt, exp_gnt);
      check_output("model.valid", 8'(bus.valid), (m_owner < 0) ? 8'd0 : 8'd1);
      check_output("model.sel", 8'(bus.sel), 8'(m_sel));
      check_output("model.ptr", 8'(bus.ptr), 8'(m_ptr));
      check_output("onehot_valid",
                   8'(($countones(bus.gnt) <= 1) && ((bus.gnt != 8'h00) == bus.valid)), 8'd1);
    end
  end

  task automatic apply_stimulus(input logic r, input logic [7:0] q, input int n);
    rst     = r;
    bus.req = q;
    repeat (n) @(negedge clk);
  endtask

  typedef struct { logic [7:0] req; int cycles; } vec_t;
  vec_t table_v[8];

  initial begin
    rst     = 1'b1;
    bus.req = 8'h00;
    @(negedge clk);

    apply_stimulus(1, 8'hFF, 3);  expect_out("rst_hold", 8'h00, 3'd0, 0, 3'd0);
    apply_stimulus(0, 8'hFF, 1);  expect_out("first_gnt", 8'h01, 3'd0, 1, 3'd0);

    apply_stimulus(0, 8'hFF, 3);  expect_out("hold4", 8'h01, 3'd0, 1, 3'd0);
    apply_stimulus(0, 8'hFF, 1);  expect_out("preempt_idle", 8'h00, 3'd0, 0, 3'd1);
    apply_stimulus(0, 8'hFF, 1);  expect_out("next_gnt1", 8'h02, 3'd1, 1, 3'd1);
    apply_stimulus(0, 8'hFF, 35); expect_out("period40", 8'h01, 3'd0, 1, 3'd0);
    apply_stimulus(0, 8'h00, 1);  expect_out("drop0", 8'h00, 3'd0, 0, 3'd1);

    apply_stimulus(0, 8'h20, 3);  expect_out("ch5_held", 8'h20, 3'd5, 1, 3'd1);
    apply_stimulus(0, 8'h00, 1);  expect_out("ch5_rel", 8'h00, 3'd5, 0, 3'd6);

    apply_stimulus(0, 8'h40, 1);  expect_out("ch6", 8'h40, 3'd6, 1, 3'd6);
    apply_stimulus(0, 8'h00, 1);  expect_out("ch6_rel", 8'h00, 3'd6, 0, 3'd7);
    apply_stimulus(0, 8'h84, 1);  expect_out("wrap7", 8'h80, 3'd7, 1, 3'd7);
    apply_stimulus(0, 8'h84, 3);  expect_out("wrap7_hold", 8'h80, 3'd7, 1, 3'd7);
    apply_stimulus(0, 8'h84, 1);  expect_out("wrap_ptr0", 8'h00, 3'd7, 0, 3'd0);
    apply_stimulus(0, 8'h84, 1);  expect_out("wrap2", 8'h04, 3'd2, 1, 3'd0);
    apply_stimulus(0, 8'h00, 1);  expect_out("wrap_ptr3", 8'h00, 3'd2, 0, 3'd3);

    apply_stimulus(0, 8'h08, 10); expect_out("solo3", 8'h08, 3'd3, 1, 3'd3);
    apply_stimulus(0, 8'h0A, 1);  expect_out("solo3_pre", 8'h00, 3'd3, 0, 3'd4);
    apply_stimulus(0, 8'h0A, 1);  expect_out("gnt1", 8'h02, 3'd1, 1, 3'd4);

    apply_stimulus(0, 8'h00, 1);  expect_out("rel1", 8'h00, 3'd1, 0, 3'd2);
    apply_stimulus(0, 8'h10, 2);  expect_out("ch4_c2", 8'h10, 3'd4, 1, 3'd2);
    apply_stimulus(1, 8'h10, 1);  expect_out("mid_rst", 8'h00, 3'd0, 0, 3'd0);
    apply_stimulus(0, 8'h10, 1);  expect_out("post_rst", 8'h10, 3'd4, 1, 3'd0);
    apply_stimulus(1, 8'h00, 1);  expect_out("rst2", 8'h00, 3'd0, 0, 3'd0);
    apply_stimulus(0, 8'h90, 1);  expect_out("search0", 8'h10, 3'd4, 1, 3'd0);
    apply_stimulus(0, 8'h90, 3);  expect_out("sim_hold", 8'h10, 3'd4, 1, 3'd0);
    apply_stimulus(0, 8'h80, 1);  expect_out("sim_rel", 8'h00, 3'd4, 0, 3'd5);
    apply_stimulus(0, 8'h80, 1);  expect_out("sim_next", 8'h80, 3'd7, 1, 3'd5);
    apply_stimulus(0, 8'h00, 1);  expect_out("sim_ptr0", 8'h00, 3'd7, 0, 3'd0);

    table_v[0] = '{8'hFF, 12};
    table_v[1] = '{8'h55, 9};
    table_v[2] = '{8'h00, 2};
    table_v[3] = '{8'h81, 7};
    table_v[4] = '{8'h3C, 14};
    table_v[5] = '{8'h01, 6};
    table_v[6] = '{8'hC3, 11};
    table_v[7] = '{8'h00, 3};
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(0, table_v[i].req, table_v[i].cycles);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
